axis_sink_checker: RTL and testbench
====================================

Name: axis_sink_checker

Overview:
- Synthesizable, parametrised AXI-Stream sink that terminates one output stream of the engine, on-chip or in simulation.
- Generates throttled tready from an LFSR with a run-time threshold.
- Counts accepted beats, words and packets; checks tlast placement, tkeep shape and AXIS stability.
- Raises done after a programmed number of packets, so benches and board tests run without a behavioural sink.

Parameters:
- WORD_BITS, 8, bits per data word (one tkeep bit per word).
- BUS_WIDTH, 128, tdata width; must be a multiple of WORD_BITS.
- KEEP_WIDTH, BUS_WIDTH/WORD_BITS, tkeep width.
- CNT_BITS, 32, width of all counters and count configs.
- LFSR_SEED, 16'hACE1, non-zero reset/restart seed of the 16-bit LFSR.

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- s_axis_tvalid  in  1  stream valid
- s_axis_tready  out  1  stream ready, registered
- s_axis_tlast  in  1  end of packet
- s_axis_tdata  in  BUS_WIDTH  payload
- s_axis_tkeep  in  KEEP_WIDTH  word enables
- cfg_start  in  1  one-cycle pulse; latches config, clears counters/errors, enters RUN
- cfg_beats_per_pkt  in  CNT_BITS  expected beats per packet, >=1
- cfg_num_pkts  in  CNT_BITS  packets before done, >=1
- cfg_ready_thresh  in  8  ready probability in 1/128 units; >=128 means always ready
- busy  out  1  high in RUN
- done  out  1  high in DONE
- err_flags  out  4  sticky: [0] LAST_EARLY, [1] LAST_MISSING, [2] KEEP, [3] UNSTABLE
- beat_count  out  CNT_BITS  accepted beats
- word_count  out  CNT_BITS  accepted words (sum of popcount(tkeep))
- pkt_count  out  CNT_BITS  completed packets

Behaviour:
- Reset values: all outputs 0, state IDLE, LFSR = LFSR_SEED.
- Handshake: a beat is accepted when s_axis_tvalid & s_axis_tready at a rising edge of aclk. Counters update on the cycle after acceptance.
- States:
  - IDLE: tready=0. cfg_start latches all cfg_*, clears counters and err_flags, reloads LFSR, moves to RUN.
  - RUN: busy=1. The LFSR (Galois, taps 16,14,13,11) steps every cycle. The next tready is (lfsr[6:0] < cfg_ready_thresh). Threshold 0 means tready stays 0. tready may fall without a handshake (legal AXIS).
  - DONE: done=1, tready=0. cfg_start restarts exactly as from IDLE.
- cfg_start in RUN is ignored. cfg inputs are sampled only on cfg_start.
- Per-packet beat index:
  - Resets to 0 on every tlast beat.
  - tlast accepted with index < cfg_beats_per_pkt-1 sets LAST_EARLY; the packet still completes.
  - A beat accepted at index = cfg_beats_per_pkt-1 without tlast sets LAST_MISSING. The packet is counted as complete and the index restarts.
  - Later beats up to the next tlast belong to the following packet.
- pkt_count increments on every packet completion. When it reaches cfg_num_pkts: tready is forced 0 from the next cycle, state goes to DONE, and no further beats are accepted.
- KEEP error: tkeep zero, non-contiguous (not of the form 0..01..1), or partial on a non-last beat. The beat is still counted, with the word count equal to popcount.
- UNSTABLE error: tvalid was high with tready low in cycle n, and in cycle n+1 tvalid drops or tdata/tkeep/tlast change. Checked in RUN only.
- Counters saturate at all-ones; no wrap.
- Asynchronous reset mid-RUN returns to IDLE immediately; tready drops asynchronously.

Optional Feature:
- Macro: AXIS_SINK_CHECKSUM_EN.
- When defined:
  - Extra output pkt_checksum (32 bits) and pulse pkt_checksum_valid.
  - Running 32-bit modular sum of kept words (zero-extended) over each packet.
  - Presented with a one-cycle valid pulse the cycle after the packet completes.
  - Accumulator clears on packet completion and on cfg_start.
- When undefined: ports absent, no accumulator logic.

Test Plan:
- thresh=128, beats=4, pkts=2, 8 beats with full tkeep and tlast on beats 4 and 8 -> tready high every RUN cycle; beat_count=8, word_count=128, pkt_count=2, done=1, err_flags=0.
- thresh=0 with tvalid held high 50 cycles -> tready stays 0, beat_count=0, busy=1; then thresh=64 via restart, seed 16'hACE1 -> tready pattern bit-exact to a reference LFSR model.
- beats=4, tlast on beat 2 -> err_flags[0]=1, pkt_count=1; next packet of 5 beats without tlast -> err_flags[1]=1 after beat 4.
- Last beat tkeep=16'h00FF -> no error, word_count +8; tkeep=16'h0F0F on any beat -> err_flags[2]=1; tkeep=16'h00FF on a non-last beat -> err_flags[2]=1.
- tvalid high with tready low, tdata changed the next cycle -> err_flags[3]=1; assert aresetn=0 mid-packet -> all outputs 0, IDLE; cfg_start then clears errors.
- With AXIS_SINK_CHECKSUM_EN: packet words 1,2,3,4 (WORD_BITS=8, single-word keep) -> pkt_checksum=10 with a one-cycle pkt_checksum_valid.

Source files
------------

// File: rtl/axis_sink_checker.sv
// -----------------------------------------------------------------------------
// axis_sink_checker
//
// Terminating AXI-Stream sink. Throttles s_axis_tready with a 16-bit Galois
// LFSR compared against a run-time threshold, counts accepted beats / words /
// packets, flags tlast placement, tkeep shape and stall-stability violations,
// and raises done after a programmed number of packets.
//
// Optional feature (compile-time macro AXIS_SINK_CHECKSUM_EN):
//   adds pkt_checksum / pkt_checksum_valid, a per-packet 32-bit modular sum of
//   the kept words, presented with a one-cycle valid the cycle after the
//   packet completes.
//
// Ports:
//   aclk, aresetn          clock, asynchronous active-low reset
//   s_axis_*               sink side of the stream (tready is registered)
//   cfg_start              one-cycle pulse: latch cfg_*, clear counts/errors, run
//   cfg_beats_per_pkt      expected beats per packet (>=1)
//   cfg_num_pkts           packets before done (>=1)
//   cfg_ready_thresh       ready probability in 1/128 units (>=128: always)
//   busy / done            RUN / DONE state indicators
//   err_flags              sticky {UNSTABLE, KEEP, LAST_MISSING, LAST_EARLY}
//   beat_count, word_count, pkt_count   saturating counters
// -----------------------------------------------------------------------------
module axis_sink_checker #(
  parameter int unsigned WORD_BITS  = 8,
  parameter int unsigned BUS_WIDTH  = 128,
  parameter int unsigned KEEP_WIDTH = BUS_WIDTH / WORD_BITS,
  parameter int unsigned CNT_BITS   = 32,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [BUS_WIDTH-1:0]  s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  cfg_start,
  input  logic [CNT_BITS-1:0]   cfg_beats_per_pkt,
  input  logic [CNT_BITS-1:0]   cfg_num_pkts,
  input  logic [7:0]            cfg_ready_thresh,
  output logic                  busy,
  output logic                  done,
  output logic [3:0]            err_flags,
  output logic [CNT_BITS-1:0]   beat_count,
  output logic [CNT_BITS-1:0]   word_count,
  output logic [CNT_BITS-1:0]   pkt_count
`ifdef AXIS_SINK_CHECKSUM_EN
  ,
  output logic [31:0]           pkt_checksum,
  output logic                  pkt_checksum_valid
`endif
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t                state_q;
  logic [15:0]           lfsr_q;
  logic [CNT_BITS-1:0]   beats_q, npkts_q;
  logic [7:0]            thresh_q;
  logic [CNT_BITS-1:0]   idx_q, beat_q, word_q, pkt_q;
  logic [3:0]            err_q;
  logic                  tready_q, busy_q, done_q;
  // Previous-cycle view of the bus for the stall-stability check.
  logic                  stall_q, prev_last_q;
  logic [BUS_WIDTH-1:0]  prev_data_q;
  logic [KEEP_WIDTH-1:0] prev_keep_q;

  logic [15:0]           lfsr_d;
  logic                  in_run, accept, at_end, complete, finish;
  logic [3:0]            err_set_d;
  logic [CNT_BITS-1:0]   beat_d, word_d, pkt_d;
  logic [KEEP_WIDTH-1:0] word_diff;

  function automatic logic [CNT_BITS-1:0] sat_add(input logic [CNT_BITS-1:0] a,
                                                  input logic [CNT_BITS-1:0] b);
    logic [CNT_BITS:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_BITS] ? '1 : s[CNT_BITS-1:0];
  endfunction

  function automatic logic [CNT_BITS-1:0] popcnt(input logic [KEEP_WIDTH-1:0] k);
    logic [CNT_BITS-1:0] c;
    c = '0;
    for (int i = 0; i < int'(KEEP_WIDTH); i++) c = c + CNT_BITS'(k[i]);
    return c;
  endfunction

  // Per-word change detector against the stalled beat.
  for (genvar gi = 0; gi < int'(KEEP_WIDTH); gi++) begin : g_word_diff
    assign word_diff[gi] = s_axis_tdata[gi*WORD_BITS +: WORD_BITS]
                           != prev_data_q[gi*WORD_BITS +: WORD_BITS];
  end

  always_comb begin
    // Right-shifting Galois LFSR, taps 16,14,13,11.
    lfsr_d   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    in_run   = (state_q == ST_RUN);
    accept   = in_run & s_axis_tvalid & tready_q;
    at_end   = (idx_q == beats_q - CNT_BITS'(1));
    // A packet closes on tlast, or on the expected last index without tlast.
    complete = accept & (s_axis_tlast | at_end);
    err_set_d[0] = accept & s_axis_tlast & ~at_end;
    err_set_d[1] = accept & ~s_axis_tlast & at_end;
    // tkeep must be non-zero, of form 0..01..1, and full unless tlast.
    err_set_d[2] = accept & ((s_axis_tkeep == '0)
                   | ((s_axis_tkeep & (s_axis_tkeep + KEEP_WIDTH'(1))) != '0)
                   | (~s_axis_tlast & (s_axis_tkeep != '1)));
    err_set_d[3] = in_run & stall_q & (~s_axis_tvalid | (|word_diff)
                   | (s_axis_tkeep != prev_keep_q) | (s_axis_tlast != prev_last_q));
    beat_d   = sat_add(beat_q, CNT_BITS'(1));
    word_d   = sat_add(word_q, popcnt(s_axis_tkeep));
    pkt_d    = sat_add(pkt_q, CNT_BITS'(1));
    finish   = complete & (pkt_d >= npkts_q);
  end

`ifdef AXIS_SINK_CHECKSUM_EN
  logic [31:0] csum_acc_q, csum_q, csum_beat;
  logic        csum_valid_q;

  always_comb begin
    csum_beat = '0;
    for (int i = 0; i < int'(KEEP_WIDTH); i++)
      if (s_axis_tkeep[i]) csum_beat = csum_beat + 32'(s_axis_tdata[i*WORD_BITS +: WORD_BITS]);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      csum_acc_q   <= '0;
      csum_q       <= '0;
      csum_valid_q <= 1'b0;
    end else begin
      csum_valid_q <= 1'b0;
      if (state_q != ST_RUN) begin
        if (cfg_start) csum_acc_q <= '0;
      end else if (accept) begin
        if (complete) begin
          csum_q       <= csum_acc_q + csum_beat;
          csum_valid_q <= 1'b1;
          csum_acc_q   <= '0;
        end else begin
          csum_acc_q   <= csum_acc_q + csum_beat;
        end
      end
    end
  end

  assign pkt_checksum       = csum_q;
  assign pkt_checksum_valid = csum_valid_q;
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= ST_IDLE;
      lfsr_q      <= LFSR_SEED;
      beats_q     <= '0;
      npkts_q     <= '0;
      thresh_q    <= '0;
      idx_q       <= '0;
      beat_q      <= '0;
      word_q      <= '0;
      pkt_q       <= '0;
      err_q       <= '0;
      tready_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      stall_q     <= 1'b0;
      prev_last_q <= 1'b0;
      prev_data_q <= '0;
      prev_keep_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (cfg_start) begin
            state_q  <= ST_RUN;
            beats_q  <= cfg_beats_per_pkt;
            npkts_q  <= cfg_num_pkts;
            thresh_q <= cfg_ready_thresh;
            idx_q    <= '0;
            beat_q   <= '0;
            word_q   <= '0;
            pkt_q    <= '0;
            err_q    <= '0;
            stall_q  <= 1'b0;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
            lfsr_q   <= LFSR_SEED;
            // tready always reflects the LFSR value held in the same cycle.
            tready_q <= ({1'b0, LFSR_SEED[6:0]} < cfg_ready_thresh);
          end
        end
        ST_RUN: begin
          lfsr_q      <= lfsr_d;
          tready_q    <= finish ? 1'b0 : ({1'b0, lfsr_d[6:0]} < thresh_q);
          stall_q     <= s_axis_tvalid & ~tready_q;
          prev_data_q <= s_axis_tdata;
          prev_keep_q <= s_axis_tkeep;
          prev_last_q <= s_axis_tlast;
          err_q       <= err_q | err_set_d;
          if (accept) begin
            beat_q <= beat_d;
            word_q <= word_d;
            idx_q  <= complete ? '0 : idx_q + CNT_BITS'(1);
          end
          if (complete) pkt_q <= pkt_d;
          if (finish) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign s_axis_tready = tready_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err_flags     = err_q;
  assign beat_count    = beat_q;
  assign word_count    = word_q;
  assign pkt_count     = pkt_q;

endmodule

// File: tb/tb_axis_sink_checker.sv
// Self-checking bench for axis_sink_checker: randomized stimulus checked
// against a transaction-level reference model kept in this file.
module tb_axis_sink_checker;

  localparam int WB = 8;
  localparam int BW = 128;
  localparam int KW = 16;
  localparam int CB = 32;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic          s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [BW-1:0] s_axis_tdata;
  logic [KW-1:0] s_axis_tkeep;
  logic          cfg_start;
  logic [CB-1:0] cfg_beats_per_pkt, cfg_num_pkts;
  logic [7:0]    cfg_ready_thresh;
  logic          busy, done;
  logic [3:0]    err_flags;
  logic [CB-1:0] beat_count, word_count, pkt_count;
`ifdef AXIS_SINK_CHECKSUM_EN
  logic [31:0]   pkt_checksum;
  logic          pkt_checksum_valid;
`endif

  always #5 aclk = ~aclk;

  axis_sink_checker #(.WORD_BITS(WB), .BUS_WIDTH(BW), .KEEP_WIDTH(KW), .CNT_BITS(CB),
                      .LFSR_SEED(16'hACE1)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .cfg_start(cfg_start), .cfg_beats_per_pkt(cfg_beats_per_pkt),
    .cfg_num_pkts(cfg_num_pkts), .cfg_ready_thresh(cfg_ready_thresh),
    .busy(busy), .done(done), .err_flags(err_flags),
    .beat_count(beat_count), .word_count(word_count), .pkt_count(pkt_count)
`ifdef AXIS_SINK_CHECKSUM_EN
    , .pkt_checksum(pkt_checksum), .pkt_checksum_valid(pkt_checksum_valid)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [BW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
  } beat_t;
  beat_t q[$];

  // Reference model state
  logic [15:0] m_lfsr;
  int          m_thresh, m_bpp, m_npk;
  int          m_beats, m_words, m_pkts, m_idx;
  logic [3:0]  m_err;
  bit          m_done;
  logic [31:0] m_acc, m_cs_val;

  // Polynomial x^16+x^14+x^13+x^11+1 in right-shifting Galois form.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  function automatic void model_accept(input beat_t b, output bit fin);
    int n, pos;
    n = $countones(b.k);
    m_beats++;
    m_words += n;
    for (int i = 0; i < KW; i++) if (b.k[i]) m_acc = m_acc + 32'(b.d[i*WB +: WB]);
    if (n == 0 || int'(b.k) != (1 << n) - 1 || (!b.l && n != KW)) m_err[2] = 1'b1;
    pos = m_idx + 1;
    fin = 1'b0;
    if (b.l) begin
      if (pos < m_bpp) m_err[0] = 1'b1;
      fin = 1'b1;
    end else if (pos == m_bpp) begin
      m_err[1] = 1'b1;
      fin = 1'b1;
    end
    if (fin) begin
      m_pkts++;
      m_idx    = 0;
      m_cs_val = m_acc;
      m_acc    = '0;
      if (m_pkts >= m_npk) m_done = 1'b1;
    end else begin
      m_idx = pos;
    end
  endfunction

  task automatic push(input logic [KW-1:0] k, input logic l);
    beat_t b;
    b.d = {$urandom, $urandom, $urandom, $urandom};
    b.k = k;
    b.l = l;
    q.push_back(b);
  endtask

  // Optional async reset, then a cfg_start pulse; model restarts alongside.
  task automatic start(input bit do_reset, input int thr, input int bpp, input int npk);
    s_axis_tvalid = 1'b0;
    if (do_reset) begin
      aresetn = 1'b0;
      #2;
      aresetn = 1'b1;
      @(posedge aclk); #1;
    end
    cfg_ready_thresh  = 8'(thr);
    cfg_beats_per_pkt = CB'(bpp);
    cfg_num_pkts      = CB'(npk);
    cfg_start = 1'b1;
    @(posedge aclk); #1;
    cfg_start = 1'b0;
    m_lfsr = 16'hACE1; m_thresh = thr; m_bpp = bpp; m_npk = npk;
    m_beats = 0; m_words = 0; m_pkts = 0; m_idx = 0; m_err = '0; m_done = 1'b0;
    m_acc = '0; m_cs_val = '0;
  endtask

  // Presents the queued beats with random gaps, holding each beat until it is
  // accepted, and checks every cycle's tready against the model LFSR.
  task automatic play_queue(input int gap_pct, input int max_cycles);
    int    cyc;
    bit    acc, fin, exp_rdy;
    beat_t cur;
    cyc = 0;
    s_axis_tvalid = 1'b0;
    cur = '{default: '0};
    while ((q.size() > 0 || s_axis_tvalid) && !m_done && cyc < max_cycles) begin
      if (!s_axis_tvalid && q.size() > 0 && int'($urandom_range(99)) >= gap_pct) begin
        cur = q.pop_front();
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = cur.d;
        s_axis_tkeep  = cur.k;
        s_axis_tlast  = cur.l;
      end
      exp_rdy = (int'(m_lfsr[6:0]) < m_thresh);
      vectors++;
      if (s_axis_tready !== exp_rdy) begin
        miscompares++;
        $display("FAIL tready cyc %0d: got %b want %b", cyc, s_axis_tready, exp_rdy);
      end
      acc = s_axis_tvalid && exp_rdy;
      @(posedge aclk); #1;
      cyc++;
      m_lfsr = lfsr_next(m_lfsr);
      fin = 1'b0;
      if (acc) begin
        model_accept(cur, fin);
        s_axis_tvalid = 1'b0;
      end
`ifdef AXIS_SINK_CHECKSUM_EN
      vectors++;
      if (pkt_checksum_valid !== fin || (fin && pkt_checksum !== m_cs_val)) begin
        miscompares++;
        $display("FAIL checksum: got v=%b %0d want v=%b %0d", pkt_checksum_valid,
                 pkt_checksum, fin, m_cs_val);
      end
`endif
    end
    if ((q.size() > 0 || s_axis_tvalid) && !m_done) begin
      vectors++;
      miscompares++;
      $display("FAIL stream_timeout: got %0d beats left want 0", q.size());
    end
    q.delete();
    s_axis_tvalid = 1'b0;
  endtask

  task automatic test_reset();
    aresetn = 1'b0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    s_axis_tdata = '0; s_axis_tkeep = '0; cfg_start = 1'b0;
    cfg_beats_per_pkt = '0; cfg_num_pkts = '0; cfg_ready_thresh = '0;
    repeat (2) @(posedge aclk);
    #1;
    vectors++;
    if ({s_axis_tready, busy, done, err_flags} !== 7'd0 ||
        {beat_count, word_count, pkt_count} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got rdy=%b busy=%b done=%b err=%h beats=%0d words=%0d pkts=%0d want all 0",
               s_axis_tready, busy, done, err_flags, beat_count, word_count, pkt_count);
    end
    aresetn = 1'b1;
    s_axis_tvalid = 1'b1;
    @(posedge aclk); #1;
    vectors++;
    if (s_axis_tready !== 1'b0 || busy !== 1'b0 || beat_count !== '0) begin
      miscompares++;
      $display("FAIL idle_hold: got rdy=%b busy=%b beats=%0d want 0 0 0", s_axis_tready, busy, beat_count);
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic test_full_ready();
    start(1'b0, 128, 4, 2);
    for (int i = 1; i <= 8; i++) push(16'hFFFF, (i % 4) == 0);
    play_queue(0, 100);
    vectors++;
    if (beat_count !== 32'd8 || word_count !== 32'd128 || pkt_count !== 32'd2) begin
      miscompares++;
      $display("FAIL full_counts: got %0d/%0d/%0d want 8/128/2", beat_count, word_count, pkt_count);
    end
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0 || err_flags !== 4'h0 || s_axis_tready !== 1'b0) begin
      miscompares++;
      $display("FAIL full_status: got done=%b busy=%b err=%h rdy=%b want 1 0 0 0",
               done, busy, err_flags, s_axis_tready);
    end
  endtask

  task automatic test_thresh_zero();
    start(1'b0, 0, 4, 2);
    s_axis_tvalid = 1'b1; s_axis_tdata = {$urandom, $urandom, $urandom, $urandom};
    s_axis_tkeep = 16'hFFFF; s_axis_tlast = 1'b0;
    for (int c = 0; c < 50; c++) begin
      vectors++;
      if (s_axis_tready !== 1'b0) begin
        miscompares++;
        $display("FAIL zero_thresh_rdy cyc %0d: got %b want 0", c, s_axis_tready);
      end
      @(posedge aclk); #1;
    end
    vectors++;
    if (beat_count !== '0 || busy !== 1'b1 || err_flags !== 4'h0) begin
      miscompares++;
      $display("FAIL zero_thresh_state: got beats=%0d busy=%b err=%h want 0 1 0", beat_count, busy, err_flags);
    end
    start(1'b1, 64, 3, 4);
    for (int i = 1; i <= 12; i++) push(16'hFFFF, (i % 3) == 0);
    play_queue(30, 2000);
    vectors++;
    if (beat_count !== 32'd12 || pkt_count !== 32'd4 || done !== 1'b1 || err_flags !== 4'h0) begin
      miscompares++;
      $display("FAIL thresh64: got beats=%0d pkts=%0d done=%b err=%h want 12 4 1 0",
               beat_count, pkt_count, done, err_flags);
    end
  endtask

  task automatic test_last_errors();
    start(1'b1, $urandom_range(40, 128), 4, 10);
    push(16'hFFFF, 1'b0); push(16'hFFFF, 1'b1);
    play_queue(20, 1000);
    vectors++;
    if (err_flags !== 4'b0001 || pkt_count !== 32'd1) begin
      miscompares++;
      $display("FAIL last_early: got err=%h pkts=%0d want 1 1", err_flags, pkt_count);
    end
    for (int i = 0; i < 4; i++) push(16'hFFFF, 1'b0);
    play_queue(20, 1000);
    vectors++;
    if (err_flags !== 4'b0011 || pkt_count !== 32'd2) begin
      miscompares++;
      $display("FAIL last_missing: got err=%h pkts=%0d want 3 2", err_flags, pkt_count);
    end
    push(16'hFFFF, 1'b0);
    play_queue(20, 1000);
    vectors++;
    if (beat_count !== 32'd7 || word_count !== 32'd112 || pkt_count !== 32'd2 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL last_followon: got beats=%0d words=%0d pkts=%0d done=%b want 7 112 2 0",
               beat_count, word_count, pkt_count, done);
    end
  endtask

  task automatic test_keep();
    start(1'b1, 128, 2, 1);
    push(16'hFFFF, 1'b0); push(16'h00FF, 1'b1);
    play_queue(0, 100);
    vectors++;
    if (err_flags !== 4'h0 || word_count !== 32'd24 || done !== 1'b1) begin
      miscompares++;
      $display("FAIL keep_partial_last: got err=%h words=%0d done=%b want 0 24 1", err_flags, word_count, done);
    end
    start(1'b0, 128, 1, 1);
    vectors++;
    if (busy !== 1'b1 || done !== 1'b0 || word_count !== '0) begin
      miscompares++;
      $display("FAIL restart_from_done: got busy=%b done=%b words=%0d want 1 0 0", busy, done, word_count);
    end
    push(16'h0F0F, 1'b1);
    play_queue(0, 100);
    vectors++;
    if (err_flags !== 4'b0100 || word_count !== 32'd8) begin
      miscompares++;
      $display("FAIL keep_gap: got err=%h words=%0d want 4 8", err_flags, word_count);
    end
    start(1'b0, 128, 2, 1);
    vectors++;
    if (err_flags !== 4'h0) begin
      miscompares++;
      $display("FAIL start_clears_err: got %h want 0", err_flags);
    end
    push(16'h00FF, 1'b0); push(16'hFFFF, 1'b1);
    play_queue(0, 100);
    vectors++;
    if (err_flags !== 4'b0100 || word_count !== 32'd24) begin
      miscompares++;
      $display("FAIL keep_partial_mid: got err=%h words=%0d want 4 24", err_flags, word_count);
    end
    start(1'b0, 128, 1, 1);
    push(16'h0000, 1'b1);
    play_queue(0, 100);
    vectors++;
    if (err_flags !== 4'b0100 || word_count !== '0 || beat_count !== 32'd1) begin
      miscompares++;
      $display("FAIL keep_zero: got err=%h words=%0d beats=%0d want 4 0 1", err_flags, word_count, beat_count);
    end
  endtask

  task automatic test_unstable();
    for (int k = 0; k < 3; k++) begin
      start(1'b1, 0, 4, 2);
      s_axis_tvalid = 1'b1; s_axis_tdata = {$urandom, $urandom, $urandom, $urandom};
      s_axis_tkeep = 16'hFFFF; s_axis_tlast = 1'b0;
      @(posedge aclk); #1;
      vectors++;
      if (err_flags !== 4'h0) begin
        miscompares++;
        $display("FAIL stable_hold k%0d: got %h want 0", k, err_flags);
      end
      case (k)
        0:       s_axis_tdata[37] = ~s_axis_tdata[37];
        1:       s_axis_tvalid = 1'b0;
        default: s_axis_tlast = 1'b1;
      endcase
      @(posedge aclk); #1;
      vectors++;
      if (err_flags !== 4'b1000) begin
        miscompares++;
        $display("FAIL unstable k%0d: got %h want 8", k, err_flags);
      end
      s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    end
    // Async reset mid-packet while tready is high.
    start(1'b1, 128, 4, 4);
    push(16'hFFFF, 1'b0); push(16'hFFFF, 1'b0);
    play_queue(0, 100);
    vectors++;
    if (s_axis_tready !== 1'b1 || beat_count !== 32'd2) begin
      miscompares++;
      $display("FAIL pre_reset: got rdy=%b beats=%0d want 1 2", s_axis_tready, beat_count);
    end
    #2 aresetn = 1'b0;
    #1;
    vectors++;
    if ({s_axis_tready, busy, done, err_flags} !== 7'd0 ||
        {beat_count, word_count, pkt_count} !== '0) begin
      miscompares++;
      $display("FAIL async_reset: got rdy=%b busy=%b done=%b err=%h beats=%0d want all 0",
               s_axis_tready, busy, done, err_flags, beat_count);
    end
    aresetn = 1'b1;
    @(posedge aclk); #1;
    start(1'b0, 128, 4, 1);
    vectors++;
    if (busy !== 1'b1 || err_flags !== 4'h0 || s_axis_tready !== 1'b1) begin
      miscompares++;
      $display("FAIL post_reset_start: got busy=%b err=%h rdy=%b want 1 0 1", busy, err_flags, s_axis_tready);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      int bpp, npk, len, n;
      bpp = $urandom_range(1, 5);
      npk = $urandom_range(2, 5);
      start(1'b1, $urandom_range(16, 200), bpp, npk);
      for (int p = 0; p < npk + 1; p++) begin
        len = bpp + $urandom_range(0, 2) - 1;
        if (len < 1) len = 1;
        for (int b = 1; b <= len; b++) begin
          logic [KW-1:0] k;
          n = $urandom_range(1, KW);
          k = (b == len) ? KW'((32'd1 << n) - 1) : 16'hFFFF;
          if ($urandom_range(9) == 0) k = KW'($urandom);
          push(k, b == len);
        end
      end
      play_queue($urandom_range(0, 40), 4000);
      vectors++;
      if (beat_count !== CB'(m_beats) || word_count !== CB'(m_words) || pkt_count !== CB'(m_pkts)) begin
        miscompares++;
        $display("FAIL random%0d_counts: got %0d/%0d/%0d want %0d/%0d/%0d", it,
                 beat_count, word_count, pkt_count, m_beats, m_words, m_pkts);
      end
      vectors++;
      if (err_flags !== m_err || done !== m_done || busy !== !m_done) begin
        miscompares++;
        $display("FAIL random%0d_status: got err=%h done=%b busy=%b want %h %b %b", it,
                 err_flags, done, busy, m_err, m_done, !m_done);
      end
    end
  endtask

`ifdef AXIS_SINK_CHECKSUM_EN
  task automatic test_checksum();
    beat_t b;
    start(1'b1, 128, 4, 1);
    for (int w = 1; w <= 4; w++) begin
      b.d = BW'(w); b.k = 16'h0001; b.l = (w == 4);
      q.push_back(b);
    end
    play_queue(0, 100);
    vectors++;
    if (pkt_checksum_valid !== 1'b1 || pkt_checksum !== 32'd10) begin
      miscompares++;
      $display("FAIL checksum_10: got v=%b %0d want 1 10", pkt_checksum_valid, pkt_checksum);
    end
    @(posedge aclk); #1;
    vectors++;
    if (pkt_checksum_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL checksum_pulse: got %b want 0", pkt_checksum_valid);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_full_ready();
    test_thresh_zero();
    test_last_errors();
    test_keep();
    test_unstable();
    test_random();
`ifdef AXIS_SINK_CHECKSUM_EN
    test_checksum();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
